masked_bram_burst_writer: RTL and testbench

//  Parametrised masked-write engine for the connected-domain filter BRAM. On one trigger it writes a

---
 rtl/masked_bram_burst_writer.sv | 170 +++++++++++++++++
 tb/tb_masked_bram_burst_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_bram_burst_writer.sv
// Masked burst writer: LEN words from base address, mask-only (2 cycles/word) or RMW (3 cycles/word), +1 DONE cycle.
// Word stream stalls on i_wdata_valid; BRAM requests are held until ack or the ACK_TIMEOUT abort.
module masked_bram_burst_writer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 13,
  parameter int LEN_W       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_rmw,
  input  logic [DATA_W-1:0] i_data_mask,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_bram_wr_trig,
  input  logic              i_bram_wr_ack,
  output logic              o_bram_rd_trig,
  input  logic              i_bram_rd_ack,
  input  logic [DATA_W-1:0] i_bram_rdata
);

  localparam int              CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam bit              TMO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_rem;
  logic                r_rmw;
  logic [DATA_W-1:0]   r_mask;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_bram_wdata;
  logic [CNT_W-1:0]    r_tcnt;
  logic                r_err;
  logic                r_wdata_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_wr_trig;
  logic                r_rd_trig;
  logic                w_tmo;

  // Last allowed cycle in RD/WR; an ack on this cycle still wins over the abort.
  assign w_tmo = TMO_EN && (r_tcnt == TMO_LAST);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_trig) begin
          w_nxt = (i_len == '0) ? S_DONE : S_GET;
        end
      end
      S_GET: begin
        if (i_wdata_valid) begin
          w_nxt = r_rmw ? S_RD : S_WR;
        end
      end
      S_RD: begin
        if (i_bram_rd_ack) begin
          w_nxt = S_WR;
        end else if (w_tmo) begin
          w_nxt = S_DONE;
        end
      end
      S_WR: begin
        if (i_bram_wr_ack) begin
          w_nxt = (r_rem == LEN_W'(1)) ? S_DONE : S_GET;
        end else if (w_tmo) begin
          w_nxt = S_DONE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_rem         <= '0;
      r_rmw         <= 1'b0;
      r_mask        <= '0;
      r_wdata       <= '0;
      r_bram_wdata  <= '0;
      r_tcnt        <= '0;
      r_err         <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wr_trig     <= 1'b0;
      r_rd_trig     <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_wdata_ready <= (w_nxt == S_GET);
      r_busy        <= (w_nxt == S_GET) || (w_nxt == S_RD) || (w_nxt == S_WR);
      r_done        <= (w_nxt == S_DONE);
      r_rd_trig     <= (w_nxt == S_RD);
      r_wr_trig     <= (w_nxt == S_WR);
      r_tcnt        <= (w_nxt != r_state) ? '0 : r_tcnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (i_trig) begin
            r_addr <= i_base_addr;
            r_rem  <= i_len;
            r_rmw  <= i_rmw;
            r_mask <= i_data_mask;
            r_err  <= 1'b0;
          end
        end
        S_GET: begin
          if (i_wdata_valid) begin
            r_wdata <= i_wdata;
            if (!r_rmw) begin
              r_bram_wdata <= i_wdata & r_mask;
            end
          end
        end
        S_RD: begin
          if (i_bram_rd_ack) begin
            r_bram_wdata <= (i_bram_rdata & ~r_mask) | (r_wdata & r_mask);
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        S_WR: begin
          if (i_bram_wr_ack) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem != LEN_W'(1)) begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_wdata_ready  = r_wdata_ready;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_bram_addr    = r_addr;
  assign o_bram_wdata   = r_bram_wdata;
  assign o_bram_wr_trig = r_wr_trig;
  assign o_bram_rd_trig = r_rd_trig;

endmodule

// File: tb/tb_masked_bram_burst_writer.sv
// Directed bench for masked_bram_burst_writer: scoreboard of expected BRAM writes, BRAM/word-source responders.
module tb_masked_bram_burst_writer;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int LW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_trig = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [LW-1:0] i_len = '0;
  logic          i_rmw = 1'b0;
  logic [DW-1:0] i_data_mask = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          i_wdata_valid = 1'b0;
  logic          o_wdata_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [AW-1:0] o_bram_addr;
  logic [DW-1:0] o_bram_wdata;
  logic          o_bram_wr_trig;
  logic          i_bram_wr_ack = 1'b0;
  logic          o_bram_rd_trig;
  logic          i_bram_rd_ack = 1'b0;
  logic [DW-1:0] i_bram_rdata = '0;

  masked_bram_burst_writer #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .ACK_TIMEOUT(4)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trig(i_trig), .i_base_addr(i_base_addr),
    .i_len(i_len), .i_rmw(i_rmw), .i_data_mask(i_data_mask), .i_wdata(i_wdata),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_bram_addr(o_bram_addr), .o_bram_wdata(o_bram_wdata),
    .o_bram_wr_trig(o_bram_wr_trig), .i_bram_wr_ack(i_bram_wr_ack),
    .o_bram_rd_trig(o_bram_rd_trig), .i_bram_rd_ack(i_bram_rd_ack), .i_bram_rdata(i_bram_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rmw;
  } wr_exp_t;

  wr_exp_t       sb[$];
  logic [DW-1:0] words[$];
  int            widx = 0;
  int            feed_gap = 0;
  int            wr_delay = 0;
  int            rd_delay = 0;
  logic [DW-1:0] rd_val = '0;
  bit            rd_pend = 1'b0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  int            wr_run = 0;
  int            last_wr_run = 0;
  int            wr_acks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // BRAM port model: acks after a programmable number of request cycles, pops the scoreboard per write.
  initial begin
    int      wcnt;
    int      rcnt;
    wr_exp_t e;
    wcnt = 0;
    rcnt = 0;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_bram_wr_trig) begin
        i_bram_wr_ack = (wcnt == wr_delay);
        wcnt++;
        if (i_bram_wr_ack) begin
          wr_acks++;
          check("sb_has_entry", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_addr", o_bram_addr, e.addr);
            check("wr_data", o_bram_wdata, e.data);
            check("rd_before_wr", rd_pend, e.rmw);
          end
          rd_pend = 1'b0;
        end
      end else begin
        i_bram_wr_ack = 1'b0;
        wcnt = 0;
      end
      if (o_bram_rd_trig) begin
        i_bram_rd_ack = (rcnt == rd_delay);
        rcnt++;
        if (i_bram_rd_ack) begin
          i_bram_rdata = rd_val;
          rd_pend = 1'b1;
        end
      end else begin
        i_bram_rd_ack = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Word source: offers the next word while the engine is in GET, optionally after a gap.
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_wdata_ready && widx < words.size()) begin
        if (gap < feed_gap) begin
          i_wdata_valid = 1'b0;
          gap++;
        end else begin
          i_wdata_valid = 1'b1;
          i_wdata = words[widx];
          widx++;
          gap = 0;
        end
      end else begin
        i_wdata_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #3;
      if (o_done) done_cnt++;
      if (o_bram_wr_trig) wr_run++;
      else if (wr_run > 0) begin
        last_wr_run = wr_run;
        wr_run = 0;
      end
    end
  end

  task automatic start(input logic [AW-1:0] base, input logic [LW-1:0] len,
                       input logic rmw, input logic [DW-1:0] mask);
    @(posedge i_clk);
    #1;
    i_base_addr = base;
    i_len = len;
    i_rmw = rmw;
    i_data_mask = mask;
    i_trig = 1'b1;
    @(posedge i_clk);
    #1;
    i_trig = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!o_done && cyc < 200) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_ready"}, o_wdata_ready, 0);
    check({tag, "_wr_trig"}, o_bram_wr_trig, 0);
    check({tag, "_rd_trig"}, o_bram_rd_trig, 0);
    check({tag, "_addr"}, o_bram_addr, 0);
    check({tag, "_wdata"}, o_bram_wdata, 0);
  endtask

  initial begin
    int cyc;
    int snap;
    #1 i_rst_n = 1'b0;
    #20;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // T1 mask-only burst, immediate acks
    words = '{32'hAAAA5555, 32'hAAAA5556, 32'hAAAA5557};
    widx = 0;
    sb.push_back('{13'h010, 32'h00005555, 1'b0});
    sb.push_back('{13'h011, 32'h00005556, 1'b0});
    sb.push_back('{13'h012, 32'h00005557, 1'b0});
    start(13'h010, 8'd3, 1'b0, 32'h0000FFFF);
    check("t1_busy", o_busy, 1);
    wait_done(cyc);
    check("t1_latency", cyc, 7);
    check("t1_err", o_err, 0);
    check("t1_busy_in_done", o_busy, 0);
    @(posedge i_clk);
    #1;
    check("t1_done_one_cycle", o_done, 0);
    check("t1_sb_empty", sb.size(), 0);

    // T2 read-modify-write, two words
    rd_val = 32'h12345678;
    words = '{32'hFFFFFFFF, 32'h0000FF00};
    widx = 0;
    sb.push_back('{13'h100, 32'h12FF56FF, 1'b1});
    sb.push_back('{13'h101, 32'h12005600, 1'b1});
    start(13'h100, 8'd2, 1'b1, 32'h00FF00FF);
    wait_done(cyc);
    check("t2_latency", cyc, 7);
    check("t2_err", o_err, 0);
    check("t2_sb_empty", sb.size(), 0);

    // T2b rmw with slow acks and a stalled word source
    rd_val = 32'hDEADBEEF;
    rd_delay = 2;
    wr_delay = 1;
    feed_gap = 2;
    words = '{32'h12345678};
    widx = 0;
    sb.push_back('{13'h200, 32'h1E3D5E7F, 1'b1});
    start(13'h200, 8'd1, 1'b1, 32'hF0F0F0F0);
    wait_done(cyc);
    check("t2b_latency", cyc, 9);
    check("t2b_err", o_err, 0);
    check("t2b_sb_empty", sb.size(), 0);
    rd_delay = 0;
    wr_delay = 0;
    feed_gap = 0;

    // T3 address wrap
    words = '{32'h00000001, 32'h00000002};
    widx = 0;
    sb.push_back('{13'h1FFF, 32'h00000001, 1'b0});
    sb.push_back('{13'h0000, 32'h00000002, 1'b0});
    start(13'h1FFF, 8'd2, 1'b0, 32'hFFFFFFFF);
    wait_done(cyc);
    check("t3_latency", cyc, 5);
    check("t3_sb_empty", sb.size(), 0);

    // T4 write ack never arrives
    wr_delay = 1000;
    words = '{32'h00000033, 32'h00000044};
    widx = 0;
    start(13'h020, 8'd2, 1'b0, 32'hFFFFFFFF);
    wait_done(cyc);
    check("t4_latency", cyc, 6);
    check("t4_err_at_done", o_err, 1);
    @(posedge i_clk);
    #4;
    check("t4_wr_req_cycles", last_wr_run, 4);
    check("t4_err_sticky", o_err, 1);
    check("t4_words_taken", widx, 1);

    // T4b next trig clears err; ack on the last allowed cycle succeeds
    wr_delay = 3;
    words = '{32'hFFFFFFFF};
    widx = 0;
    sb.push_back('{13'h030, 32'h0F0F0F0F, 1'b0});
    start(13'h030, 8'd1, 1'b0, 32'h0F0F0F0F);
    check("t4b_err_cleared", o_err, 0);
    wait_done(cyc);
    check("t4b_latency", cyc, 6);
    check("t4b_err", o_err, 0);
    check("t4b_sb_empty", sb.size(), 0);
    wr_delay = 0;

    // T5 zero-length burst
    snap = wr_acks;
    words.delete();
    widx = 0;
    start(13'h040, 8'd0, 1'b0, 32'h0000FFFF);
    wait_done(cyc);
    check("t5_latency", cyc, 1);
    check("t5_busy", o_busy, 0);
    check("t5_no_wr_req", o_bram_wr_trig, 0);
    check("t5_no_writes", wr_acks - snap, 0);

    // T5b trig while busy and in DONE is ignored
    words = '{32'h00000005, 32'h00000006};
    widx = 0;
    sb.push_back('{13'h050, 32'h00000005, 1'b0});
    sb.push_back('{13'h051, 32'h00000006, 1'b0});
    start(13'h050, 8'd2, 1'b0, 32'hFFFFFFFF);
    i_base_addr = 13'h777;
    i_len = 8'd9;
    i_trig = 1'b1;
    wait_done(cyc);
    check("t5b_latency", cyc, 5);
    snap = done_cnt;
    @(posedge i_clk);
    #1;
    i_trig = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("t5b_idle_after", o_busy, 0);
    check("t5b_single_done", done_cnt - snap, 1);
    check("t5b_sb_empty", sb.size(), 0);

    // T6 reset while a read is outstanding
    rd_delay = 1000;
    words = '{32'h00000001};
    widx = 0;
    start(13'h060, 8'd1, 1'b1, 32'h0000FFFF);
    cyc = 0;
    while (!o_bram_rd_trig && cyc < 20) begin
      @(posedge i_clk);
      #1;
      cyc++;
    end
    check("t6_rd_req_seen", o_bram_rd_trig, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    snap = done_cnt;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    check("t6_no_done", done_cnt - snap, 0);
    check("t6_no_rd_req", o_bram_rd_trig, 0);
    rd_delay = 0;
    words = '{32'hCAFEF00D};
    widx = 0;
    sb.push_back('{13'h070, 32'hCAFE0000, 1'b0});
    start(13'h070, 8'd1, 1'b0, 32'hFFFF0000);
    wait_done(cyc);
    check("t6_restart_latency", cyc, 3);
    check("t6_restart_err", o_err, 0);
    check("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
